// File: rtl/seg_scan_driver.sv
// seg_scan_driver: four-digit 7-seg scanner that requests codes, captures and decodes them to active-low segments.
// Optional SEG_GHOST_BLANK_EN blanks the pins until the freshly captured code reaches them.
module seg_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W = 16,
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] msg_code,
  output logic       ref_sign,
  output logic [1:0] refresh,
  output logic [3:0] an,
  output logic [7:0] seg
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(LAT);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [5:0] msg_buf [4];
  logic wrap, blank;
  function automatic logic [7:0] glyph(input logic [5:0] c);
    case (c)
      6'd0:  return 8'hC0;
      6'd1:  return 8'hF9;
      6'd2:  return 8'hA4;
      6'd3:  return 8'hB0;
      6'd4:  return 8'h99;
      6'd5:  return 8'h92;
      6'd6:  return 8'h82;
      6'd7:  return 8'hF8;
      6'd8:  return 8'h80;
      6'd9:  return 8'h90;
      6'd10: return 8'h88;
      6'd11: return 8'h83;
      6'd12: return 8'hC6;
      6'd13: return 8'hA1;
      6'd14: return 8'h86;
      6'd15: return 8'h8E;
      6'd16: return 8'hC2;
      6'd17: return 8'h89;
      6'd18: return 8'hCF;
      6'd19: return 8'hE1;
      6'd21: return 8'hC7;
      6'd23: return 8'hAB;
      6'd24: return 8'hC0;
      6'd25: return 8'h8C;
      6'd26: return 8'h98;
      6'd27: return 8'hAF;
      6'd28: return 8'h92;
      6'd29: return 8'h87;
      6'd30: return 8'hC1;
      6'd34: return 8'h91;
      6'd35: return 8'hA4;
      6'd36: return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction
  assign wrap = cnt == LAST;
  assign cnt_nxt = wrap ? '0 : cnt + 1'b1;
`ifdef SEG_GHOST_BLANK_EN
  assign blank = cnt_nxt <= CNT_W'(LAT + 1);
`else
  assign blank = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= LAST;
      refresh <= 2'd3;
      ref_sign <= 1'b0;
      an <= 4'hF;
      seg <= 8'hFF;
      for (int i = 0; i < 4; i++) msg_buf[i] <= 6'd37;
    end else begin
      cnt <= cnt_nxt;
      ref_sign <= wrap;
      if (wrap) refresh <= refresh + 2'd1;
      if (cnt == CAP) msg_buf[refresh] <= msg_code;
      // display reads the pre-capture entry; no bypass
      an <= blank ? 4'hF : ~(4'b0001 << refresh);
      seg <= blank ? 8'hFF : glyph(msg_buf[refresh]);
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver with SCAN_DIV=8, LAT=2.
module tb_seg_scan_driver;
  localparam int SD = 8;
  localparam int LT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] msg_code = 6'd0;
  logic ref_sign;
  logic [1:0] refresh;
  logic [3:0] an;
  logic [7:0] seg;
  typedef struct {logic [3:0] an; logic [7:0] seg;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int mcnt, mref;
  logic [7:0] shown [4];
  logic [5:0] codes [4];

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(SD), .CNT_W(16), .LAT(LT)) dut (
    .clk(clk), .rst(rst), .msg_code(msg_code), .ref_sign(ref_sign),
    .refresh(refresh), .an(an), .seg(seg)
  );

  function automatic logic [7:0] exp_glyph(input logic [5:0] c);
    case (c)
      6'd0:  return 8'hC0;
      6'd5:  return 8'h92;
      6'd9:  return 8'h90;
      6'd10: return 8'h88;
      6'd25: return 8'h8C;
      6'd28: return 8'h92;
      6'd36: return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] sel(input int r);
    logic [3:0] v;
    v = 4'b0001 << r;
    return ~v;
  endfunction

  task automatic model_reset;
    mcnt = SD - 1;
    mref = 3;
    for (int i = 0; i < 4; i++) shown[i] = 8'hFF;
    sb.delete();
  endtask

  task automatic cycle;
    exp_t e;
    @(posedge clk);
    #1;
    mcnt = (mcnt == SD - 1) ? 0 : mcnt + 1;
    if (mcnt == 0) mref = (mref + 1) % 4;
    checks += 2;
    if (ref_sign !== (mcnt == 0)) begin
      errors++;
      $display("FAIL ref_sign cnt=%0d got %b want %b", mcnt, ref_sign, mcnt == 0);
    end
    if (refresh !== 2'(mref)) begin
      errors++;
      $display("FAIL refresh cnt=%0d got %0d want %0d", mcnt, refresh, mref);
    end
    if (mcnt == LT) begin
      msg_code = codes[mref];
      sb.push_back('{sel(mref), exp_glyph(codes[mref])});
    end else msg_code = 6'($urandom_range(0, 63));
`ifdef SEG_GHOST_BLANK_EN
    if (mcnt <= LT + 1) begin
      checks++;
      if (an !== 4'hF || seg !== 8'hFF) begin
        errors++;
        $display("FAIL ghost_blank cnt=%0d got %h/%h want F/FF", mcnt, an, seg);
      end
    end
`else
    if (mcnt == 1) begin
      checks++;
      if (an !== sel(mref) || seg !== shown[mref]) begin
        errors++;
        $display("FAIL early_digit d=%0d got %b/%h want %b/%h", mref, an, seg, sel(mref), shown[mref]);
      end
    end
`endif
    if (mcnt == LT + 2) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty d=%0d got %b/%h want queued entry", mref, an, seg);
      end else begin
        e = sb.pop_front();
        if (an !== e.an || seg !== e.seg) begin
          errors++;
          $display("FAIL display d=%0d got %b/%h want %b/%h", mref, an, seg, e.an, e.seg);
        end
        shown[mref] = e.seg;
      end
    end
  endtask

  task automatic run_to(input int c, input int r);
    int w = 0;
    while (!(mcnt == c && mref == r) && w < 8 * SD) begin
      cycle();
      w++;
    end
    if (!(mcnt == c && mref == r)) begin
      checks++;
      errors++;
      $display("FAIL run_to timeout got cnt=%0d/ref=%0d want %0d/%0d", mcnt, mref, c, r);
    end
  endtask

  task automatic test_reset;
    model_reset();
    codes = '{6'd37, 6'd37, 6'd37, 6'd37};
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %h want F", an); end
    if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want FF", seg); end
    if (ref_sign !== 1'b0) begin errors++; $display("FAIL reset_ref_sign got %b want 0", ref_sign); end
    if (refresh !== 2'd3) begin errors++; $display("FAIL reset_refresh got %0d want 3", refresh); end
    rst = 1'b0;
    cycle();
    checks++;
    if (ref_sign !== 1'b1 || refresh !== 2'd0) begin
      errors++;
      $display("FAIL first_strobe got %b/%0d want 1/0", ref_sign, refresh);
    end
  endtask

  task automatic test_cadence;
    for (int k = 0; k < 5; k++) begin
      int w = 0;
      do begin
        cycle();
        w++;
      end while (ref_sign !== 1'b1 && w < 2 * SD);
      checks++;
      if (w != SD || refresh !== 2'((k + 1) % 4)) begin
        errors++;
        $display("FAIL cadence k=%0d got gap %0d ref %0d want gap %0d ref %0d", k, w, refresh, SD, (k + 1) % 4);
      end
    end
  endtask

  task automatic test_pass_frame;
    logic [3:0] pan [4];
    logic [7:0] pseg [4];
    pan = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    pseg = '{8'h92, 8'h92, 8'h88, 8'h8C};
    codes = '{6'd28, 6'd28, 6'd10, 6'd25};
    repeat (8 * SD) cycle();
    for (int d = 0; d < 4; d++) begin
      run_to(5, d);
      checks++;
      if (an !== pan[d] || seg !== pseg[d]) begin
        errors++;
        $display("FAIL pass_frame d=%0d got %b/%h want %b/%h", d, an, seg, pan[d], pseg[d]);
      end
    end
  endtask

  task automatic test_decode;
    codes = '{6'd0, 6'd9, 6'd36, 6'd63};
    repeat (8 * SD) cycle();
    codes = '{6'd20, 6'd22, 6'd31, 6'd5};
    repeat (8 * SD) cycle();
  endtask

  task automatic test_mid_reset;
    codes = '{6'd28, 6'd28, 6'd10, 6'd25};
    repeat (4 * SD) cycle();
    run_to(1, 2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 8'hFF || ref_sign !== 1'b0 || refresh !== 2'd3) begin
      errors++;
      $display("FAIL async_reset got %h/%h/%b/%0d want F/FF/0/3", an, seg, ref_sign, refresh);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (8 * SD) cycle();
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_pass_frame();
    test_decode();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the four-digit seven-segment display and the consumer side of the message-refresh interface. It generates the digit-request strobe `ref_sign` and the digit index `refresh` that every state's message generator answers. It captures the 6-bit character code returned on `msg_code` and decodes it to active-low segments. The block sits between the top-level state-message multiplexer and the board display pins.

## Interface
- `SCAN_DIV`, 50000: clock cycles each digit is held (one scan slot); legal range LAT+4 … 2^CNT_W.
- `CNT_W`, 16: slot counter width.
- `LAT`, 2: cycles from a `ref_sign` cycle to the cycle in which `msg_code` is valid; legal range 1…7.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `msg_code` in 6: character code from the selected message generator.
- `ref_sign` out 1: one-cycle digit-request strobe.
- `refresh` out 2: index of the requested/displayed digit (0 = rightmost).
- `an` out 4: digit enables, active-low; `an[3]` is the leftmost digit.
- `seg` out 8: segments `{dp,g,f,e,d,c,b,a}`, active-low.

## Operation
- Slot counter `cnt` counts from 0 to SCAN_DIV-1, then wraps to 0.
- On the wrap edge, `refresh` increments mod 4. `ref_sign` is registered high for exactly the cycle in which `cnt==0`.
- Capture: on the edge ending the cycle with `cnt==LAT`, `msg_code` is written into `buf[refresh]`. The buffer holds four 6-bit codes.
- Display: `an = ~(4'b1 << refresh)` and `seg = glyph(buf[refresh])`. Both are registered.
- Code map:
  - 0–9 are digits.
  - 10–35 are letters A–Z (A=10, P=25, S=28).
  - 36 is '-'.
  - 37–63 are blank.
  - Letters with no usable glyph (K, M, V, W, X) are blank.
- Required glyphs: 0=C0, 5=92, 9=90, A=88, P=8C, S=92, '-'=BF, blank=FF. The rest of the letter glyphs follow the team's 7-seg font sheet.
- `msg_code` is sampled every slot, even when its value is unchanged. A generator that holds its value simply re-delivers it.

## Timing
- Reset values:
  - `cnt = SCAN_DIV-1`, `refresh = 3`, `ref_sign = 0`.
  - `an = 4'hF`, `seg = 8'hFF`.
  - All `buf` entries = 37 (blank).
- First edge after reset release: `cnt=0`, `refresh=0`, `ref_sign=1`.
- Cadence: `ref_sign` recurs every SCAN_DIV cycles with `refresh` stepping 0,1,2,3,0,…
- Capture-to-pin latency: a code captured at `cnt==LAT` appears on `seg` in the cycle with `cnt==LAT+2`.
- Reset mid-slot: outputs and buffer return to reset values immediately (asynchronously). A partially elapsed slot is discarded.
- Simultaneous events: capture and display read of the same entry in one cycle means the display shows the old value for that cycle. No bypass.
- Changing `msg_code` outside the `cnt==LAT` cycle has no effect.

## Configuration
- `SEG_GHOST_BLANK_EN` defined: `an=4'hF` and `seg=8'hFF` at the pins while `cnt` is in 0…LAT+1, i.e. blank until the new code reaches the pins. This prevents the previous frame's glyph ghosting on the newly selected digit.
- Not defined: `an` switches to the new digit at `cnt==1`. `seg` shows the previous frame's `buf[refresh]` until the new capture propagates at `cnt==LAT+2`.

## Test plan
1. **Reset.** Hold `rst` high → `an=F`, `seg=FF`, `ref_sign=0`, `refresh=3`. Release → next cycle `ref_sign=1`, `refresh=0`.
2. **Strobe cadence.** SCAN_DIV=8 → `ref_sign` is high one cycle every 8 cycles; `refresh` reads 0,1,2,3,0 across five strobes.
3. **PASS frame.** SCAN_DIV=8, LAT=2, bench generator returns 28,28,10,25 for `refresh` 0..3 with 2-cycle latency. After one full frame, at `cnt==5` of each slot: `an=1110/seg=92`, `1101/92`, `1011/88`, `0111/8C`.
4. **Decode.** Present codes 0, 9, 36, 63 in successive slots → `seg` reads C0, 90, BF, FF in the corresponding slots.
5. **Blanking.**
   - With `SEG_GHOST_BLANK_EN`: `cnt` 0..3 → `an=F`, `seg=FF`.
   - Without it: at `cnt==1`, `an=~(1<<refresh)` and `seg` equals the previous frame's glyph.
6. **Mid-operation reset.** Pulse `rst` at `cnt==1`, `refresh==2` after a PASS frame → `an=F` and `seg=FF` asynchronously. After release, all digits show blank until recaptured, and `ref_sign` restarts with `refresh=0`.
